// File: rtl/bus_ram_slave.sv
// ============================================================================
//  Module      : bus_ram_slave
//  Description : RAM responder for the 8-bit cs/we/ack system bus. It inserts
//                WAIT_STATES wait cycles and then returns a one-cycle ack.
//                Define BUSRAM_WPROT_EN to drop writes at or above WP_BASE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_ram_slave #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    MEM_AW      = 12,
    parameter int                    WAIT_STATES = 1,
    parameter logic [ADDR_WIDTH-1:0] WP_BASE     = 16'hF000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_dat,
    input  logic                  i_cs,
    input  logic                  i_we,
    output logic [7:0]            o_dat,
    output logic                  o_ack,
    output logic                  o_busy,
    output logic                  o_wp_hit
);

    localparam int         c_depth    = 1 << MEM_AW;
    localparam logic [3:0] c_cnt_init = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [MEM_AW-1:0] r_idx;
    logic              r_we;
    logic [7:0]        r_wdat;
    logic              w_commit;
    logic [7:0]        r_mem [c_depth];

`ifdef BUSRAM_WPROT_EN
    logic r_wp;

    // The protection decision is taken at latch time, on the full address.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wp     <= 1'b0;
            o_wp_hit <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_cs)
                r_wp <= i_we && (i_addr >= WP_BASE);
            o_wp_hit <= (r_state == S_ACK) && r_we && r_wp;
        end
    end

    assign w_commit = (r_state == S_ACK) && r_we && !r_wp;
`else
    logic w_unused_addr;

    assign w_unused_addr = ^i_addr[ADDR_WIDTH-1:MEM_AW];
    assign o_wp_hit      = 1'b0;
    assign w_commit      = (r_state == S_ACK) && r_we;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cs)
                    w_next = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                if (!i_cs)
                    w_next = S_IDLE;
                else if (r_cnt == 4'd0)
                    w_next = S_ACK;
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Completion (ack, read data) is registered on the edge that leaves ACK.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt  <= 4'd0;
            r_idx  <= '0;
            r_we   <= 1'b0;
            r_wdat <= 8'h00;
            o_dat  <= 8'h00;
            o_ack  <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            o_ack  <= (r_state == S_ACK);
            o_busy <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (i_cs) begin
                        r_idx  <= i_addr[MEM_AW-1:0];
                        r_we   <= i_we;
                        r_wdat <= i_dat;
                        r_cnt  <= c_cnt_init;
                    end
                end
                S_WAIT: begin
                    if (i_cs && r_cnt != 4'd0)
                        r_cnt <= r_cnt - 4'd1;
                end
                S_ACK: begin
                    if (!r_we)
                        o_dat <= r_mem[r_idx];
                end
                default: ;
            endcase
        end
    end

    // RAM contents survive reset; a write coinciding with reset is dropped.
    always_ff @(posedge i_clk) begin
        if (w_commit && !i_reset)
            r_mem[r_idx] <= r_wdat;
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_ram_slave.sv
// ============================================================================
//  Module      : tb_bus_ram_slave
//  Description : Self-checking bench for bus_ram_slave with a byte-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_ram_slave;

    localparam int WS    = 3;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  wdat;
    logic        cs;
    logic        we;
    logic [7:0]  rdat;
    logic        ack;
    logic        busy;
    logic        wp_hit;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mdl_mem   [DEPTH];
    bit         mdl_known [DEPTH];
    logic [7:0] exp_dat;
    bit         exp_dat_known;

    bus_ram_slave #(
        .ADDR_WIDTH (16),
        .MEM_AW     (12),
        .WAIT_STATES(WS),
        .WP_BASE    (16'hF000)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_addr  (addr),
        .i_dat   (wdat),
        .i_cs    (cs),
        .i_we    (we),
        .o_dat   (rdat),
        .o_ack   (ack),
        .o_busy  (busy),
        .o_wp_hit(wp_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit protected_write(input logic [15:0] a, input logic w);
`ifdef BUSRAM_WPROT_EN
        return w && (a >= 16'hF000);
`else
        return 1'b0;
`endif
    endfunction

    // One complete access; expected latency is WS+2 edges counting the sampling edge.
    task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d, input bit drop);
        int idx;
        int lat;
        bit prot;
        idx  = int'(a) % DEPTH;
        prot = protected_write(a, w);
        @(negedge clk);
        cs = 1'b1; addr = a; we = w; wdat = d;
        lat = 0;
        for (int k = 1; k <= WS + 8 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (ack)
                lat = k;
            else
                chk("busy_during", {31'd0, busy}, {31'd0, (k <= WS + 1)});
        end
        chk("latency", lat, WS + 2);
        chk("busy_at_ack", {31'd0, busy}, 32'd0);
        chk("wp_hit", {31'd0, wp_hit}, {31'd0, prot});
        if (w) begin
            if (!prot) begin
                mdl_mem[idx]   = d;
                mdl_known[idx] = 1'b1;
            end
        end else begin
            exp_dat       = mdl_mem[idx];
            exp_dat_known = mdl_known[idx];
        end
        if (exp_dat_known)
            chk(w ? "dat_after_write" : "read_data", {24'd0, rdat}, {24'd0, exp_dat});
        if (drop) begin
            cs = 1'b0;
            @(posedge clk); #1;
            chk("ack_single_cycle", {31'd0, ack}, 32'd0);
            chk("wp_hit_single_cycle", {31'd0, wp_hit}, 32'd0);
        end
    endtask

    initial begin
        logic [11:0] pool [8];
        for (int i = 0; i < DEPTH; i++) mdl_known[i] = 1'b0;
        rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 16'h0; wdat = 8'h0;
        exp_dat = 8'h00; exp_dat_known = 1'b1;

        // Reset state and idle bus
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dat", {24'd0, rdat}, 32'h00);
        chk("rst_wp", {31'd0, wp_hit}, 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("idle_no_ack", {30'd0, ack, busy}, 32'd0);
        end

        // Write then read back, then back-to-back access
        access(16'h0123, 1'b1, 8'hA5, 1'b1);
        access(16'h0123, 1'b0, 8'h00, 1'b1);
        access(16'h0124, 1'b1, 8'h5A, 1'b0);
        access(16'h0124, 1'b0, 8'h00, 1'b1);

        // Aborted read: cs dropped while waiting
        @(negedge clk);
        cs = 1'b1; addr = 16'h0010; we = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        cs = 1'b0;
        for (int i = 0; i < WS + 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_ack", {31'd0, ack}, 32'd0);
        end
        chk("abort_idle", {31'd0, busy}, 32'd0);
        chk("abort_dat_kept", {24'd0, rdat}, {24'd0, exp_dat});
        access(16'h0123, 1'b0, 8'h00, 1'b1);

        // Address aliasing above the RAM depth
        access(16'h1005, 1'b1, 8'h3C, 1'b1);
        access(16'h0005, 1'b0, 8'h00, 1'b1);

        // Reset in the middle of a write
        access(16'h0200, 1'b1, 8'h44, 1'b1);
        @(negedge clk);
        cs = 1'b1; addr = 16'h0200; we = 1'b1; wdat = 8'h77;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; cs = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_dat", {24'd0, rdat}, 32'h00);
        #2 rst = 1'b0;
        exp_dat = 8'h00; exp_dat_known = 1'b1;
        for (int i = 0; i < WS + 4; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_ack", {31'd0, ack}, 32'd0);
        end
        access(16'h0200, 1'b0, 8'h00, 1'b1);

        // Write protection boundary
        access(16'hF000, 1'b1, 8'h11, 1'b1);
        access(16'hEFFF, 1'b1, 8'h22, 1'b1);
        access(16'hF000, 1'b0, 8'h00, 1'b1);
        access(16'hEFFF, 1'b0, 8'h00, 1'b1);

        // Randomized traffic over a small address pool with random upper bits
        for (int i = 0; i < 8; i++) pool[i] = 12'($urandom_range(0, DEPTH - 1));
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            ra = {4'($urandom_range(0, 15)), pool[$urandom_range(0, 7)]};
            access(ra, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        @(negedge clk); cs = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
